// File: rtl/nn_inference_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// nn_parameters
//   Shared types and defaults for the speech-recognition inference sequencer.
//   - DEFAULT_NUM_LAYERS : default number of sequenced network layers
//   - class_t            : 2-bit decision produced by final_layer
//   - CLASS_NONE         : silence / reject decision, never issued as a command
//   - seq_state_t        : frame sequencer states
// -----------------------------------------------------------------------------
package nn_parameters;

  localparam int DEFAULT_NUM_LAYERS = 4;

  typedef logic [1:0] class_t;

  localparam class_t CLASS_NONE = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DECIDE = 3'd4,
    ST_ABORT  = 3'd5
  } seq_state_t;

endpackage

// File: rtl/nn_inference_sequencer_class_filter.sv
// -----------------------------------------------------------------------------
// nn_class_filter
//   Debounces per-frame decisions: a command is issued only once the same
//   non-silence class has been seen CONFIRM frames in a row, and only once
//   per run of identical decisions.
//   Ports:
//     clk, rst    : clock, asynchronous active-low reset
//     en          : take class_in as this frame's decision
//     clear       : forget the running streak (aborted frame)
//     class_in    : decision from final_layer
//     cmd_valid   : registered one-cycle command pulse
//     cmd_class   : last confirmed class, held between pulses
// -----------------------------------------------------------------------------
module nn_class_filter
  import nn_parameters::*;
#(
  parameter int CONFIRM = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   clear,
  input  class_t class_in,
  output logic   cmd_valid,
  output class_t cmd_class
);

  localparam int SW = $clog2(CONFIRM + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(CONFIRM);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);

  logic [SW-1:0] streak_r;
  logic [SW-1:0] streak_s;
  class_t        last_class_r;
  logic          same_s;
  logic          issue_s;
  logic          cmd_valid_r;
  class_t        cmd_class_r;

  // Next streak value and command decision for the current decision.
  always_comb begin
    same_s   = (class_in == last_class_r);
    streak_s = STREAK_ONE;
    if (same_s) begin
      if (streak_r == STREAK_MAX) begin
        streak_s = streak_r;
      end else begin
        streak_s = streak_r + STREAK_ONE;
      end
    end else begin
      streak_s = STREAK_ONE;
    end
    // A class change starts a fresh run, so it counts as "not yet issued"
    // even when the saturated old streak equals CONFIRM (matters for CONFIRM=1).
    issue_s = (class_in != CLASS_NONE) && (streak_s == STREAK_MAX) &&
              (!same_s || (streak_r < STREAK_MAX));
  end

  // Streak / last-class / command registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_r     <= '0;
      last_class_r <= CLASS_NONE;
      cmd_valid_r  <= 1'b0;
      cmd_class_r  <= CLASS_NONE;
    end else if (clear) begin
      streak_r     <= '0;
      last_class_r <= CLASS_NONE;
      cmd_valid_r  <= 1'b0;
    end else if (en) begin
      streak_r     <= streak_s;
      last_class_r <= class_in;
      cmd_valid_r  <= issue_s;
      if (issue_s) begin
        cmd_class_r <= class_in;
      end
    end else begin
      cmd_valid_r <= 1'b0;
    end
  end

  assign cmd_valid = cmd_valid_r;
  assign cmd_class = cmd_class_r;

endmodule

// File: rtl/nn_inference_sequencer.sv
// -----------------------------------------------------------------------------
// nn_inference_sequencer
//   Frame-level controller: accepts a feature frame, pulses each layer's
//   start in turn, waits for its done (with a per-layer watchdog), then hands
//   the final decision to nn_class_filter.
//   Ports:
//     clk, rst     : clock, asynchronous active-low reset
//     frame_valid  : feature frame available
//     frame_ready  : frame accepted this cycle if frame_valid (IDLE only)
//     layer_start  : one-hot, single-cycle start pulse per layer
//     layer_done   : per-layer completion (pulse or level)
//     class_in     : registered decision from final_layer
//     busy         : frame in progress
//     cmd_valid    : confirmed command pulse
//     cmd_class    : last confirmed class
//     timeout_err  : one-cycle pulse when a frame is aborted
// -----------------------------------------------------------------------------
module nn_inference_sequencer
  import nn_parameters::*;
#(
  parameter int NUM_LAYERS     = DEFAULT_NUM_LAYERS,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CONFIRM        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  input  class_t                class_in,
  output logic                  busy,
  output logic                  cmd_valid,
  output class_t                cmd_class,
  output logic                  timeout_err
);

  localparam int IW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LAYERS - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [WW-1:0] WD_ONE   = WW'(1);
  // The first WAIT cycle sees watchdog 0, so the last allowed WAIT cycle is
  // at TIMEOUT_CYCLES-2; ABORT then lands TIMEOUT_CYCLES after START.
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 2);

  seq_state_t    state_r;
  seq_state_t    state_s;
  logic [IW-1:0] layer_idx_r;
  logic [WW-1:0] watchdog_r;
  logic          done_s;
  logic          last_layer_s;

  assign done_s       = layer_done[layer_idx_r];
  assign last_layer_s = (layer_idx_r == LAST_IDX);

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_valid) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: state_s = ST_WAIT;
      ST_WAIT: begin
        // done takes priority over an expiring watchdog
        if (done_s) begin
          if (last_layer_s) begin
            state_s = ST_SETTLE;
          end else begin
            state_s = ST_START;
          end
        end else if (watchdog_r == WD_LAST) begin
          state_s = ST_ABORT;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_SETTLE: state_s = ST_DECIDE;
      ST_DECIDE: state_s = ST_IDLE;
      ST_ABORT:  state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Layer index and per-layer watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      layer_idx_r <= '0;
      watchdog_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (frame_valid) begin
            layer_idx_r <= '0;
          end
        end
        ST_START: watchdog_r <= '0;
        ST_WAIT: begin
          if (done_s) begin
            if (!last_layer_s) begin
              layer_idx_r <= layer_idx_r + IDX_ONE;
            end
          end else begin
            watchdog_r <= watchdog_r + WD_ONE;
          end
        end
        default: begin
          layer_idx_r <= layer_idx_r;
          watchdog_r  <= watchdog_r;
        end
      endcase
    end
  end

  // Start pulse decoded from registered state and index only.
  always_comb begin
    if (state_r == ST_START) begin
      layer_start = NUM_LAYERS'(1) << layer_idx_r;
    end else begin
      layer_start = '0;
    end
  end

  assign frame_ready = (state_r == ST_IDLE);
  assign busy        = (state_r != ST_IDLE);
  assign timeout_err = (state_r == ST_ABORT);

  // class_in is sampled on the edge that enters DECIDE: SETTLE is the cycle in
  // which the final_layer output register is guaranteed valid, and loading the
  // filter then makes cmd_valid a registered pulse coinciding with DECIDE.
  nn_class_filter #(
    .CONFIRM (CONFIRM)
  ) u_class_filter (
    .clk       (clk),
    .rst       (rst),
    .en        (state_r == ST_SETTLE),
    .clear     (state_r == ST_ABORT),
    .class_in  (class_in),
    .cmd_valid (cmd_valid),
    .cmd_class (cmd_class)
  );

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nn_inference_sequencer
//   Scenario tasks drive frames through the sequencer with a layer responder
//   that returns done in the first WAIT cycle (optionally never, for one
//   layer). A reference model of the confirmation rule pushes the expected
//   per-frame outcome to a queue, popped and compared when the frame ends.
// -----------------------------------------------------------------------------
module tb_nn_inference_sequencer;
  import nn_parameters::*;

  localparam int NL = 4;
  localparam int TO = 16;
  localparam int CF = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_valid = 1'b0;
  logic          frame_ready;
  logic [NL-1:0] layer_start;
  logic [NL-1:0] layer_done = '0;
  class_t        class_in = 2'b00;
  logic          busy;
  logic          cmd_valid;
  class_t        cmd_class;
  logic          timeout_err;

  always #5 clk = ~clk;

  nn_inference_sequencer #(
    .NUM_LAYERS     (NL),
    .TIMEOUT_CYCLES (TO),
    .CONFIRM        (CF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .layer_start (layer_start),
    .layer_done  (layer_done),
    .class_in    (class_in),
    .busy        (busy),
    .cmd_valid   (cmd_valid),
    .cmd_class   (cmd_class),
    .timeout_err (timeout_err)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    bit     cmd;
    class_t cls;
    bit     abort;
  } exp_t;

  exp_t   sb_q[$];
  int     m_run;
  class_t m_last;
  class_t m_held;

  int     obs_start_cyc[NL];
  int     obs_bad_start, obs_cmd_n, obs_to_n, obs_to_cyc, obs_end_cyc, obs_bad_ready;
  class_t obs_cmd_cls;
  bit     obs_hang;

  task automatic model_reset();
    m_run  = 0;
    m_last = CLASS_NONE;
    m_held = CLASS_NONE;
    sb_q.delete();
  endtask

  task automatic apply_reset();
    rst         = 1'b0;
    frame_valid = 1'b0;
    layer_done  = '0;
    class_in    = CLASS_NONE;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  // Reference model: a command fires exactly when a non-silence run length hits CF.
  task automatic sb_push(input class_t cls, input bit abort);
    exp_t e;
    if (abort) begin
      m_run   = 0;
      m_last  = CLASS_NONE;
      e.cmd   = 1'b0;
      e.cls   = CLASS_NONE;
      e.abort = 1'b1;
    end else begin
      if (cls == m_last) m_run++;
      else begin
        m_last = cls;
        m_run  = 1;
      end
      e.cmd   = (cls != CLASS_NONE) && (m_run == CF);
      e.cls   = cls;
      e.abort = 1'b0;
      if (e.cmd) m_held = cls;
    end
    sb_q.push_back(e);
  endtask

  // Runs one frame; cycle numbers are relative to the accepting cycle C0.
  task automatic drive_frame(input class_t cls, input int stall, input bit hold);
    logic [NL-1:0] prev;
    int c;
    int w;
    prev = '0;
    for (int k = 0; k < NL; k++) obs_start_cyc[k] = -1;
    obs_bad_start = 0; obs_cmd_n = 0; obs_to_n = 0; obs_to_cyc = -1;
    obs_end_cyc = -1; obs_bad_ready = 0; obs_cmd_cls = CLASS_NONE; obs_hang = 1'b1;
    w = 0;
    while (!frame_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    frame_valid = 1'b1;
    class_in    = cls;
    c = 0;
    while (c < 200) begin
      @(negedge clk);
      c++;
      if (!hold) frame_valid = 1'b0;
      if (layer_start != '0) begin
        if ($countones(layer_start) != 1) obs_bad_start++;
        else begin
          for (int k = 0; k < NL; k++) begin
            if (layer_start[k]) begin
              if (obs_start_cyc[k] != -1) obs_bad_start++;
              obs_start_cyc[k] = c;
            end
          end
        end
      end
      if (cmd_valid) begin
        obs_cmd_n++;
        obs_cmd_cls = cmd_class;
      end
      if (timeout_err) begin
        obs_to_n++;
        obs_to_cyc = c;
      end
      if (frame_ready === busy) obs_bad_ready++;
      layer_done = prev;
      if (stall >= 0 && stall < NL) layer_done[stall] = 1'b0;
      prev = layer_start;
      if (frame_ready) begin
        obs_end_cyc = c;
        obs_hang    = 1'b0;
        break;
      end
    end
    layer_done = '0;
    if (!hold) frame_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    frame_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({frame_ready, busy, layer_start, cmd_valid, timeout_err, cmd_class} !== {1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00}) begin
      tests_failed++;
      $display("FAIL reset_held: ready/busy/start/cmd/to/cls=%b %b %b %b %b %b", frame_ready, busy, layer_start, cmd_valid, timeout_err, cmd_class);
    end
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests_run++;
      if ({frame_ready, busy, layer_start, cmd_valid, timeout_err, cmd_class} !== {1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00}) begin
        tests_failed++;
        $display("FAIL reset_idle cyc %0d: ready/busy/start/cmd/to/cls=%b %b %b %b %b %b expected 1 0 0000 0 0 00", i, frame_ready, busy, layer_start, cmd_valid, timeout_err, cmd_class);
      end
    end
  endtask

  task automatic test_single_frame();
    exp_t e;
    apply_reset();
    sb_push(2'b01, 1'b0);
    drive_frame(2'b01, -1, 1'b0);
    e = sb_q.pop_front();
    for (int k = 0; k < NL; k++) begin
      tests_run++;
      if (obs_start_cyc[k] !== 1 + 2 * k) begin
        tests_failed++;
        $display("FAIL single_start_cyc layer %0d: got C%0d expected C%0d", k, obs_start_cyc[k], 1 + 2 * k);
      end
    end
    tests_run++;
    if (obs_bad_start !== 0) begin
      tests_failed++;
      $display("FAIL single_onehot: %0d bad start pulses, expected 0", obs_bad_start);
    end
    tests_run++;
    if (obs_end_cyc !== 11) begin
      tests_failed++;
      $display("FAIL single_ready_cyc: got C%0d expected C11", obs_end_cyc);
    end
    tests_run++;
    if (obs_cmd_n !== (e.cmd ? 1 : 0) || obs_to_n !== 0) begin
      tests_failed++;
      $display("FAIL single_no_cmd: cmd %0d to %0d expected %0d 0", obs_cmd_n, obs_to_n, e.cmd ? 1 : 0);
    end
  endtask

  task automatic test_confirm();
    class_t seq[3] = '{2'b01, 2'b01, 2'b01};
    exp_t e;
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      sb_push(seq[f], 1'b0);
      drive_frame(seq[f], -1, 1'b0);
      e = sb_q.pop_front();
      tests_run++;
      if (obs_hang || obs_cmd_n !== (e.cmd ? 1 : 0)) begin
        tests_failed++;
        $display("FAIL confirm_cmd frame %0d: cmd pulses %0d hang %0d expected %0d", f, obs_cmd_n, obs_hang, e.cmd ? 1 : 0);
      end
      if (e.cmd) begin
        tests_run++;
        if (obs_cmd_cls !== e.cls) begin
          tests_failed++;
          $display("FAIL confirm_cls frame %0d: got %b expected %b", f, obs_cmd_cls, e.cls);
        end
      end
      tests_run++;
      if (cmd_class !== m_held) begin
        tests_failed++;
        $display("FAIL confirm_hold frame %0d: cmd_class %b expected %b", f, cmd_class, m_held);
      end
    end
  endtask

  task automatic test_silence();
    class_t seq[6] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    exp_t e;
    apply_reset();
    for (int f = 0; f < 6; f++) begin
      if (f == 4) apply_reset();
      sb_push(seq[f], 1'b0);
      drive_frame(seq[f], -1, 1'b0);
      e = sb_q.pop_front();
      tests_run++;
      if (obs_hang || obs_cmd_n !== (e.cmd ? 1 : 0)) begin
        tests_failed++;
        $display("FAIL silence_cmd frame %0d: cmd pulses %0d hang %0d expected %0d", f, obs_cmd_n, obs_hang, e.cmd ? 1 : 0);
      end
    end
  endtask

  task automatic test_timeout();
    class_t seq[4]   = '{2'b01, 2'b01, 2'b01, 2'b01};
    int     stall[4] = '{-1, 2, -1, -1};
    exp_t e;
    apply_reset();
    for (int f = 0; f < 4; f++) begin
      sb_push(seq[f], stall[f] >= 0);
      drive_frame(seq[f], stall[f], 1'b0);
      e = sb_q.pop_front();
      tests_run++;
      if (obs_hang || obs_to_n !== (e.abort ? 1 : 0)) begin
        tests_failed++;
        $display("FAIL timeout_pulses frame %0d: got %0d hang %0d expected %0d", f, obs_to_n, obs_hang, e.abort ? 1 : 0);
      end
      tests_run++;
      if (obs_cmd_n !== (e.cmd ? 1 : 0)) begin
        tests_failed++;
        $display("FAIL timeout_cmd frame %0d: cmd pulses %0d expected %0d", f, obs_cmd_n, e.cmd ? 1 : 0);
      end
      if (e.abort) begin
        tests_run++;
        if (obs_to_cyc !== 1 + 2 * stall[f] + TO) begin
          tests_failed++;
          $display("FAIL timeout_cyc: got C%0d expected C%0d", obs_to_cyc, 1 + 2 * stall[f] + TO);
        end
        tests_run++;
        if (obs_end_cyc !== 2 + 2 * stall[f] + TO || obs_start_cyc[3] !== -1) begin
          tests_failed++;
          $display("FAIL timeout_end: ready C%0d start3 C%0d expected C%0d and none", obs_end_cyc, obs_start_cyc[3], 2 + 2 * stall[f] + TO);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    exp_t e;
    apply_reset();
    // reset during WAIT of layer 1
    frame_valid = 1'b1;
    class_in    = 2'b01;
    @(negedge clk);              // C1 START0
    frame_valid = 1'b0;
    @(negedge clk);              // C2 WAIT0
    layer_done = 4'b0001;
    @(negedge clk);              // C3 START1
    layer_done = 4'b0000;
    tests_run++;
    if (layer_start !== 4'b0010) begin
      tests_failed++;
      $display("FAIL midrst_start1: got %b expected 0010", layer_start);
    end
    @(negedge clk);              // C4 WAIT1
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({busy, frame_ready, layer_start, timeout_err, cmd_valid} !== {1'b0, 1'b1, 4'b0000, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL midrst_wait: busy/ready/start/to/cmd=%b %b %b %b %b expected 0 1 0000 0 0", busy, frame_ready, layer_start, timeout_err, cmd_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    // reset in a START cycle: the pulse must drop without a clock edge
    frame_valid = 1'b1;
    @(negedge clk);              // C1 START0
    frame_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (layer_start !== 4'b0000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_start_drop: start %b busy %b expected 0000 0", layer_start, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (frame_ready !== 1'b1 || timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_release: ready %b to %b expected 1 0", frame_ready, timeout_err);
    end
    sb_push(2'b01, 1'b0);
    drive_frame(2'b01, -1, 1'b0);
    e = sb_q.pop_front();
    tests_run++;
    if (obs_start_cyc[0] !== 1 || obs_end_cyc !== 11 || obs_cmd_n !== (e.cmd ? 1 : 0)) begin
      tests_failed++;
      $display("FAIL midrst_next_frame: start0 C%0d ready C%0d cmd %0d expected C1 C11 %0d", obs_start_cyc[0], obs_end_cyc, obs_cmd_n, e.cmd ? 1 : 0);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    apply_reset();
    for (int f = 0; f < 2; f++) begin
      sb_push(2'b11, 1'b0);
      drive_frame(2'b11, -1, 1'b1);
      e = sb_q.pop_front();
      tests_run++;
      if (obs_start_cyc[0] !== 1 || obs_end_cyc !== 11 || obs_bad_ready !== 0) begin
        tests_failed++;
        $display("FAIL b2b_timing frame %0d: start0 C%0d ready C%0d ready/busy clashes %0d expected C1 C11 0", f, obs_start_cyc[0], obs_end_cyc, obs_bad_ready);
      end
      tests_run++;
      if (obs_cmd_n !== (e.cmd ? 1 : 0) || (e.cmd && obs_cmd_cls !== e.cls)) begin
        tests_failed++;
        $display("FAIL b2b_cmd frame %0d: cmd %0d cls %b expected %0d %b", f, obs_cmd_n, obs_cmd_cls, e.cmd ? 1 : 0, e.cls);
      end
    end
    frame_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || frame_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_idle: busy %b ready %b expected 0 1", busy, frame_ready);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_frame();
    test_confirm();
    test_silence();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/nn_inference_sequencer.md
# nn_inference_sequencer

Frame-level controller for the speech-recognition neural network. Accepts one feature frame at a time from the feature extractor. Issues a start pulse to each network layer in turn and waits for each layer's done before moving on. After the last layer it samples the 2-bit decision produced by `final_layer`, and emits a command only when the same non-silence class is seen in `CONFIRM` consecutive frames. It sits between the feature-extraction front end and the command/output logic.

## Interface
- `NUM_LAYERS`, 4, number of sequenced layers; bit k of `layer_start`/`layer_done` belongs to layer k.
- `TIMEOUT_CYCLES`, 4096, maximum WAIT cycles allowed per layer before the frame is aborted.
- `CONFIRM`, 2, number of consecutive identical non-silence decisions required to issue a command (≥1).
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `frame_valid` in 1: a feature frame is available.
- `frame_ready` out 1: sequencer can accept a frame; high only in IDLE.
- `layer_start` out NUM_LAYERS: one-hot, single-cycle start pulse to layer k.
- `layer_done` in NUM_LAYERS: completion pulse or level from layer k.
- `class_in` in 2: registered decision from `final_layer`; 00 = silence/reject.
- `busy` out 1: high in every state except IDLE.
- `cmd_valid` out 1: one-cycle pulse when a confirmed command is issued.
- `cmd_class` out 2: last confirmed class; holds its value between pulses.
- `timeout_err` out 1: one-cycle pulse when a frame is aborted.

## Operation
- States: IDLE, START, WAIT, SETTLE, DECIDE, ABORT.
- All outputs are decoded from registered state and registers; outputs are never combinational paths from inputs.
- IDLE:
  - `frame_ready`=1.
  - On `frame_valid & frame_ready`: `layer_idx`←0, go to START.
- START:
  - `layer_start[layer_idx]`=1 for exactly this cycle.
  - Watchdog←0, go to WAIT.
  - `layer_done` is ignored in this cycle.
- WAIT:
  - Only `layer_done[layer_idx]` is sampled; other done bits are ignored.
  - On done with `layer_idx`=NUM_LAYERS-1: go to SETTLE.
  - On done otherwise: `layer_idx`++, go to START.
  - Without done: watchdog++. When the watchdog reaches TIMEOUT_CYCLES-1 without done, go to ABORT.
  - If done and timeout occur in the same cycle, done wins.
- SETTLE:
  - One idle cycle that covers the `final_layer` output register latency.
  - Then go to DECIDE.
- DECIDE: sample `class_in`.
  - If `class_in`==`last_class`: `streak`←min(`streak`+1, CONFIRM).
  - Otherwise: `streak`←1 and `last_class`←`class_in`.
  - `cmd_valid`=1 (registered, this cycle) when `class_in`≠00 and the new `streak` equals CONFIRM while the old `streak` was below CONFIRM. At most one command is issued per run of identical decisions.
  - `cmd_class` is updated together with `cmd_valid`.
  - Then go to IDLE.
- ABORT:
  - `timeout_err`=1.
  - `streak`←0, `last_class`←00.
  - Then go to IDLE.
- Reset values:
  - State IDLE, `layer_idx` 0, watchdog 0, `streak` 0, `last_class` 00.
  - `cmd_class` 00, `layer_start` 0, `cmd_valid` 0, `timeout_err` 0.
  - `busy` 0, `frame_ready` 1.
- Reset during a frame returns immediately (asynchronously) to IDLE. `layer_start` drops without waiting for a clock. The partial frame is discarded with no error pulse.

## Timing
- Frame handshake accepted at cycle C0.
- Start of layer k is issued at C(1+2k), assuming every done arrives in the first WAIT cycle.
- Fastest frame:
  - C8 WAIT for the last layer.
  - C9 SETTLE.
  - C10 DECIDE, with `cmd_valid` if the command is confirmed.
  - C11 IDLE with `frame_ready`=1.
- Minimum frame period is 11 cycles.
- Timeout: the ABORT cycle occurs TIMEOUT_CYCLES cycles after the START cycle.
- `frame_valid` held high while `busy` has no effect; it is accepted only on the next IDLE cycle.

## Structure
- `nn_parameters` package holds:
  - `NUM_LAYERS` default.
  - `class_t` (logic [1:0]) and `CLASS_NONE` = 2'b00.
  - Enum `seq_state_t` for the six states.
- One sub-module, `nn_class_filter`, owns the DECIDE-step logic: `last_class`, `streak`, the `cmd_valid`/`cmd_class` generation, and a clear input used by ABORT.
- The FSM and the watchdog live in the top module.

## Test plan
- Reset released, `frame_valid` held low → `frame_ready`=1, `busy`=0, all other outputs 0 indefinitely.
- One frame, each done returned one cycle after its start, `class_in`=01, CONFIRM=2 → `layer_start` one-hot 0001, 0010, 0100, 1000 at C1/C3/C5/C7; no `cmd_valid`; `frame_ready` at C11.
- Three frames with classes 01, 01, 01 → exactly one `cmd_valid`, on the second frame, with `cmd_class`=01; none on the third.
- Frames with classes 10, 00, 00, 10 → no command; frames with classes 00, 00 → no command (silence is never issued).
- TIMEOUT_CYCLES=16, layer 2 never asserts done → `timeout_err` one cycle, 16 cycles after its start. The following frames 01, 01 then need both frames to confirm.
- `rst` asserted during WAIT of layer 1 → `layer_start` is 0 and `busy` 0 immediately; after release `frame_ready`=1 and the next frame starts from layer 0.
